// File: rtl/pueo_command_decoder_rx_pkg.sv
//------------------------------------------------------------------------------
// pueo_cmd_pkg
// Shared definitions for the SURF-side command decoder: command type codes,
// the link training word, bit positions of the fields in the 32-bit link word,
// the command-processor FIFO entry layout and a small type classifier.
//------------------------------------------------------------------------------
package pueo_cmd_pkg;

   // Command type codes carried in the top nibble of the link word
   localparam logic [3:0] CMD_TYPE_BIT        = 4'b0000;
   localparam logic [3:0] CMD_TYPE_CPROC      = 4'b0001;
   localparam logic [3:0] CMD_TYPE_CPROC_LAST = 4'b0101;
   localparam logic [3:0] CMD_TYPE_NOP        = 4'b1010;

   // Idle pattern the TURF sends while the link is being trained
   localparam logic [31:0] TRAINING_WORD = 32'hA55A6996;

   // Field positions inside the link word
   localparam int TYPE_MSB      = 31;
   localparam int TYPE_LSB      = 28;
   localparam int LAST_BIT      = 30;
   localparam int DATA_MSB      = 27;
   localparam int DATA_LSB      = 16;
   localparam int USER_MSB      = 27;
   localparam int USER_LSB      = 24;
   localparam int BYTE_MSB      = 23;
   localparam int BYTE_LSB      = 16;
   localparam int TRIG_FLAG_BIT = 15;
   localparam int TRIG_MSB      = 14;
   localparam int TRIG_LSB      = 0;

   // Coarse classification of the type nibble
   typedef enum logic [1:0] {
      CLASS_BIT   = 2'd0,
      CLASS_CPROC = 2'd1,
      CLASS_NOP   = 2'd2,
      CLASS_RSVD  = 2'd3
   } cmdClass_t;

   // One command-processor byte as it sits in the FIFO
   typedef struct packed {
      logic [3:0] tuser;
      logic [7:0] tdata;
      logic       tlast;
   } cmdEntry_t;

   // Map a type nibble onto its class; anything unrecognised is reserved
   function automatic cmdClass_t decodeType(input logic [3:0] cmdType);
      case (cmdType)
         CMD_TYPE_BIT:                        return CLASS_BIT;
         CMD_TYPE_CPROC, CMD_TYPE_CPROC_LAST: return CLASS_CPROC;
         CMD_TYPE_NOP:                        return CLASS_NOP;
         default:                             return CLASS_RSVD;
      endcase
   endfunction

endpackage

// File: rtl/pueo_command_decoder_rx_if.sv
//------------------------------------------------------------------------------
// pueo_command_decoder_rx_if
// Groups the two outgoing streams of the command decoder.
//   cmdproc_*  : command-processor byte stream (tdata/tuser/tlast/tvalid/tready)
//   trig_*     : trigger stream (tdata/tvalid/tready)
// master : the decoder (drives data/valid, receives ready)
// slave  : the downstream consumer
//------------------------------------------------------------------------------
interface pueo_command_decoder_rx_if;

   logic [7:0]  cmdproc_tdata;
   logic [3:0]  cmdproc_tuser;
   logic        cmdproc_tlast;
   logic        cmdproc_tvalid;
   logic        cmdproc_tready;
   logic [15:0] trig_tdata;
   logic        trig_tvalid;
   logic        trig_tready;

   modport master (
      output cmdproc_tdata,
      output cmdproc_tuser,
      output cmdproc_tlast,
      output cmdproc_tvalid,
      input  cmdproc_tready,
      output trig_tdata,
      output trig_tvalid,
      input  trig_tready
   );

   modport slave (
      input  cmdproc_tdata,
      input  cmdproc_tuser,
      input  cmdproc_tlast,
      input  cmdproc_tvalid,
      output cmdproc_tready,
      input  trig_tdata,
      input  trig_tvalid,
      output trig_tready
   );

endinterface

// File: rtl/pueo_command_decoder_rx_sfifo.sv
//------------------------------------------------------------------------------
// pueo_cmd_sfifo
// Small synchronous FIFO, first-word-fall-through: o_rdData always shows the
// head entry and only moves on a pop, so it is stable while the reader stalls.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
// Ports:
//   i_clk, i_rstN      : clock, asynchronous active-low reset
//   i_wrEn, i_wrData   : push request and data
//   i_rdEn             : pop request (ignored while empty)
//   o_rdData           : head entry
//   o_empty, o_full    : occupancy status
//------------------------------------------------------------------------------
module pueo_cmd_sfifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             i_clk,
   input  logic             i_rstN,
   input  logic             i_wrEn,
   input  logic [WIDTH-1:0] i_wrData,
   input  logic             i_rdEn,
   output logic [WIDTH-1:0] o_rdData,
   output logic             o_empty,
   output logic             o_full
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wrPtr;
   logic [AW:0]      r_rdPtr;
   logic             w_push;
   logic             w_pop;

   // Pointers carry one extra wrap bit so full and empty can be told apart
   // when the low bits match.
   assign o_empty  = (r_wrPtr == r_rdPtr);
   assign o_full   = (r_wrPtr[AW] != r_rdPtr[AW]) &&
                     (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
   assign w_pop    = i_rdEn && !o_empty;
   assign w_push   = i_wrEn && (!o_full || w_pop);
   assign o_rdData = r_mem[r_rdPtr[AW-1:0]];

   // Storage and pointer update. The array is cleared on reset so the data
   // outputs read zero straight out of reset.
   always_ff @(posedge i_clk or negedge i_rstN) begin
      if (!i_rstN) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (w_push) begin
            r_mem[r_wrPtr[AW-1:0]] <= i_wrData;
            r_wrPtr                <= r_wrPtr + 1'b1;
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/pueo_command_decoder_rx.sv
//------------------------------------------------------------------------------
// pueo_command_decoder_rx
// SURF-side decoder for the TURF command link. Once per 8-clock sysclk cycle
// the deserialized word is captured, and on the next cycle (D) it is split
// into bit-command pulses, a command-processor byte stream and a trigger
// stream. The link cannot be stalled, so both streams are buffered in FIFOs
// and losses are reported through sticky overflow flags.
// Ports:
//   sysclk_i, rst_n_i   : clock, asynchronous active-low reset
//   sysclk_phase_i      : high on phase 0 of the 8-clock cycle
//   command_i           : link word, [31:28] type, [27:16] data, [15:0] trigger
//   bitcommand_o        : one-cycle bit-command pulses
//   m_axis              : command-processor and trigger streams (master side)
//   err_clear_i         : clears overflow flags and reserved counter
//   cmd_overflow_o      : sticky, a command byte was dropped
//   trig_overflow_o     : sticky, a trigger was dropped
//   reserved_count_o    : saturating count of reserved-type words
//   training_o          : only with PUEO_CMD_TRAINING_DETECT_EN defined; high
//                         after 4 consecutive training words
// Optional feature macro: PUEO_CMD_TRAINING_DETECT_EN
//------------------------------------------------------------------------------
module pueo_command_decoder_rx
   import pueo_cmd_pkg::*;
#(
   parameter int CAPTURE_PHASE   = 7,
   parameter int CMD_FIFO_DEPTH  = 16,
   parameter int TRIG_FIFO_DEPTH = 8
) (
   input  logic                        sysclk_i,
   input  logic                        rst_n_i,
   input  logic                        sysclk_phase_i,
   input  logic [31:0]                 command_i,
   output logic [11:0]                 bitcommand_o,
   pueo_command_decoder_rx_if.master   m_axis,
   input  logic                        err_clear_i,
   output logic                        cmd_overflow_o,
   output logic                        trig_overflow_o,
   output logic [7:0]                  reserved_count_o
`ifdef PUEO_CMD_TRAINING_DETECT_EN
   ,
   output logic                        training_o
`endif
);

   logic [2:0]  r_phase;
   logic        w_capture;
   logic [31:0] r_word;
   logic        r_decode;
   logic [11:0] r_bitCmd;
   logic        r_cmdOvf;
   logic        r_trigOvf;
   logic [7:0]  r_rsvdCnt;

   cmdClass_t   w_class;
   logic        w_cmdPush;
   cmdEntry_t   w_cmdIn;
   cmdEntry_t   w_cmdOut;
   logic        w_cmdEmpty;
   logic        w_cmdFull;
   logic        w_cmdDrop;
   logic        w_trigPush;
   logic [15:0] w_trigIn;
   logic        w_trigEmpty;
   logic        w_trigFull;
   logic        w_trigDrop;
   logic        w_rsvd;

   assign w_capture = (r_phase == 3'(CAPTURE_PHASE));

   // Local phase counter. The phase strobe marks phase 0, so the following
   // cycle is phase 1; otherwise it free-runs and wraps every 8 clocks.
   always_ff @(posedge sysclk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_phase <= '0;
      end else if (sysclk_phase_i) begin
         r_phase <= 3'd1;
      end else begin
         r_phase <= r_phase + 3'd1;
      end
   end

   // Capture the link word and mark the next cycle as the decode cycle.
   // The bit-command field is decoded straight from the incoming word so the
   // pulse lands on the decode cycle out of a register and is zero elsewhere.
   always_ff @(posedge sysclk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_word   <= '0;
         r_decode <= 1'b0;
         r_bitCmd <= '0;
      end else begin
         r_decode <= w_capture;
         if (w_capture) begin
            r_word <= command_i;
         end
         if (w_capture && (decodeType(command_i[TYPE_MSB:TYPE_LSB]) == CLASS_BIT)) begin
            r_bitCmd <= command_i[DATA_MSB:DATA_LSB];
         end else begin
            r_bitCmd <= '0;
         end
      end
   end

   assign bitcommand_o = r_bitCmd;

   // Decode-cycle actions on the captured word. Type bit 2 separates the
   // last byte of a command from the others, and the trigger half of the
   // word is handled regardless of type.
   assign w_class       = decodeType(r_word[TYPE_MSB:TYPE_LSB]);
   assign w_cmdPush     = r_decode && (w_class == CLASS_CPROC);
   assign w_cmdIn.tuser = r_word[USER_MSB:USER_LSB];
   assign w_cmdIn.tdata = r_word[BYTE_MSB:BYTE_LSB];
   assign w_cmdIn.tlast = r_word[LAST_BIT];
   assign w_trigPush    = r_decode && r_word[TRIG_FLAG_BIT];
   assign w_trigIn      = {1'b0, r_word[TRIG_MSB:TRIG_LSB]};
   assign w_rsvd        = r_decode && (w_class == CLASS_RSVD);

   // A push is lost only when the FIFO is full and nothing leaves it in the
   // same cycle; a full FIFO is never empty, so ready alone means a pop.
   assign w_cmdDrop  = w_cmdPush  && w_cmdFull  && !m_axis.cmdproc_tready;
   assign w_trigDrop = w_trigPush && w_trigFull && !m_axis.trig_tready;

   pueo_cmd_sfifo #(
      .WIDTH ($bits(cmdEntry_t)),
      .DEPTH (CMD_FIFO_DEPTH)
   ) u_cmdFifo (
      .i_clk    (sysclk_i),
      .i_rstN   (rst_n_i),
      .i_wrEn   (w_cmdPush),
      .i_wrData (w_cmdIn),
      .i_rdEn   (m_axis.cmdproc_tready),
      .o_rdData (w_cmdOut),
      .o_empty  (w_cmdEmpty),
      .o_full   (w_cmdFull)
   );

   pueo_cmd_sfifo #(
      .WIDTH (16),
      .DEPTH (TRIG_FIFO_DEPTH)
   ) u_trigFifo (
      .i_clk    (sysclk_i),
      .i_rstN   (rst_n_i),
      .i_wrEn   (w_trigPush),
      .i_wrData (w_trigIn),
      .i_rdEn   (m_axis.trig_tready),
      .o_rdData (m_axis.trig_tdata),
      .o_empty  (w_trigEmpty),
      .o_full   (w_trigFull)
   );

   assign m_axis.cmdproc_tdata  = w_cmdOut.tdata;
   assign m_axis.cmdproc_tuser  = w_cmdOut.tuser;
   assign m_axis.cmdproc_tlast  = w_cmdOut.tlast;
   assign m_axis.cmdproc_tvalid = !w_cmdEmpty;
   assign m_axis.trig_tvalid    = !w_trigEmpty;

   // Sticky error flags and reserved-word counter. A new event beats a
   // simultaneous clear, so nothing that happens during the clear is lost;
   // for the counter that means it restarts at one.
   always_ff @(posedge sysclk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_cmdOvf  <= 1'b0;
         r_trigOvf <= 1'b0;
         r_rsvdCnt <= '0;
      end else begin
         if (w_cmdDrop) begin
            r_cmdOvf <= 1'b1;
         end else if (err_clear_i) begin
            r_cmdOvf <= 1'b0;
         end
         if (w_trigDrop) begin
            r_trigOvf <= 1'b1;
         end else if (err_clear_i) begin
            r_trigOvf <= 1'b0;
         end
         if (err_clear_i) begin
            r_rsvdCnt <= w_rsvd ? 8'd1 : 8'd0;
         end else if (w_rsvd && (r_rsvdCnt != 8'hFF)) begin
            r_rsvdCnt <= r_rsvdCnt + 8'd1;
         end
      end
   end

   assign cmd_overflow_o   = r_cmdOvf;
   assign trig_overflow_o  = r_trigOvf;
   assign reserved_count_o = r_rsvdCnt;

`ifdef PUEO_CMD_TRAINING_DETECT_EN
   logic [1:0] r_trainRun;
   logic       r_training;

   // Training detector. r_trainRun counts matches already seen (saturating
   // at 3), so a match with three behind it is the fourth in a row. Any other
   // captured word breaks the run and drops the indication.
   always_ff @(posedge sysclk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_trainRun <= '0;
         r_training <= 1'b0;
      end else if (w_capture) begin
         if (command_i == TRAINING_WORD) begin
            if (r_trainRun == 2'd3) begin
               r_training <= 1'b1;
            end else begin
               r_trainRun <= r_trainRun + 2'd1;
            end
         end else begin
            r_trainRun <= '0;
            r_training <= 1'b0;
         end
      end
   end

   assign training_o = r_training;
`endif

endmodule
